// File: rtl/aximm_stream_client_arbiter_if.sv
// AXI-MM-over-stream link: request (TX) and response (RX) stream pair
// between the client arbiter (master) and the link/server side (slave).
interface aximm_stream_client_arbiter_if;
    logic [255:0] AXIS_TX_TDATA;
    logic         AXIS_TX_TVALID;
    logic         AXIS_TX_TLAST;
    logic         AXIS_TX_TREADY;
    logic [255:0] AXIS_RX_TDATA;
    logic         AXIS_RX_TVALID;
    logic         AXIS_RX_TLAST;
    logic         AXIS_RX_TREADY;

    modport master (
        output AXIS_TX_TDATA, AXIS_TX_TVALID, AXIS_TX_TLAST,
        input  AXIS_TX_TREADY,
        input  AXIS_RX_TDATA, AXIS_RX_TVALID, AXIS_RX_TLAST,
        output AXIS_RX_TREADY
    );

    modport slave (
        input  AXIS_TX_TDATA, AXIS_TX_TVALID, AXIS_TX_TLAST,
        output AXIS_TX_TREADY,
        output AXIS_RX_TDATA, AXIS_RX_TVALID, AXIS_RX_TLAST,
        input  AXIS_RX_TREADY
    );
endinterface

// File: rtl/aximm_stream_client_arbiter.sv
// Client-side master of the AXI-MM-over-stream link. Arbitrates NUM_REQ
// local requesters round-robin onto one request/response stream pair, one
// outstanding transaction at a time.
// Optional response timeout: define AXIS_CLIENT_TIMEOUT_EN.
module aximm_stream_client_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_is_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_resp,
    output logic [15:0]                      mismatch_count,
    aximm_stream_client_arbiter_if.master    axis
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEND    = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    localparam logic [31:0] T_READ_REQ  = 32'd1;
    localparam logic [31:0] T_WRITE_REQ = 32'd2;
    localparam logic [31:0] T_READ_RSP  = 32'd3;
    localparam logic [31:0] T_WRITE_RSP = 32'd4;

    // Request captured at grant; the packet fields are fixed 64/32 bits wide.
    typedef struct packed {
        logic             is_write;
        logic [63:0]      addr;
        logic [31:0]      wdata;
        logic [IDX_W-1:0] id;
    } req_t;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_arr;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    req_t             cur;
    logic [255:0]     tx_tdata;
    logic             tx_tvalid;
    logic             rx_tready;

    logic             grant_hit;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             tx_fire;
    logic             rx_fire;
    logic             rx_match;
    logic             timeout_hit;

    // Unpack the flat requester buses into per-lane arrays.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign axis.AXIS_TX_TDATA  = tx_tdata;
    assign axis.AXIS_TX_TVALID = tx_tvalid;
    assign axis.AXIS_TX_TLAST  = tx_tvalid;  // single-beat packets
    assign axis.AXIS_RX_TREADY = rx_tready;

    assign tx_fire = (state == S_SEND) && tx_tvalid && axis.AXIS_TX_TREADY;
    assign rx_fire = rx_tready && axis.AXIS_RX_TVALID;

    // A response belongs to us only if type, address and framing all agree.
    assign rx_match = (axis.AXIS_RX_TDATA[31:0] == (cur.is_write ? T_WRITE_RSP : T_READ_RSP))
                   && (axis.AXIS_RX_TDATA[95:32] == cur.addr)
                   && axis.AXIS_RX_TLAST;

    logic unused_rx_pad;
    assign unused_rx_pad = ^axis.AXIS_RX_TDATA[255:130];

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = rr_ptr;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_hit && req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

    function automatic logic [255:0] build_pkt(input req_t r);
        logic [255:0] p;
        p          = '0;
        p[31:0]    = r.is_write ? T_WRITE_REQ : T_READ_REQ;
        p[95:32]   = r.addr;
        p[127:96]  = r.is_write ? r.wdata : 32'd0;
        return p;
    endfunction

`ifdef AXIS_CLIENT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Cycles spent in WAIT_RSP; restarts at the request handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            to_cnt <= '0;
        else if (tx_fire)
            to_cnt <= '0;
        else if (state == S_WAIT)
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state == S_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout WAIT_RSP waits forever; the parameter is inert.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // Main transaction FSM: grant, send request, await response, deliver.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            rr_ptr         <= IDX_W'(NUM_REQ - 1);
            cur            <= '0;
            tx_tdata       <= '0;
            tx_tvalid      <= 1'b0;
            rx_tready      <= 1'b0;
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_rdata      <= '0;
            rsp_resp       <= '0;
            mismatch_count <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_hit) begin
                        req_ready <= ONE << grant_idx;
                        cur       <= '{is_write: req_is_write[grant_idx],
                                       addr:     64'(addr_arr[grant_idx]),
                                       wdata:    32'(wdata_arr[grant_idx]),
                                       id:       grant_idx};
                        rr_ptr    <= grant_idx;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_tvalid) begin
                        tx_tvalid <= 1'b1;
                        tx_tdata  <= build_pkt(cur);
                    end else if (axis.AXIS_TX_TREADY) begin
                        tx_tvalid <= 1'b0;
                        rx_tready <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rx_fire && rx_match) begin
                        rx_tready <= 1'b0;
                        rsp_rdata <= DATA_WIDTH'(axis.AXIS_RX_TDATA[127:96]);
                        rsp_resp  <= axis.AXIS_RX_TDATA[129:128];
                        rsp_valid <= ONE << cur.id;
                        state     <= S_DELIVER;
                    end else begin
                        if (rx_fire && (mismatch_count != 16'hFFFF))
                            mismatch_count <= mismatch_count + 16'd1;
                        if (timeout_hit) begin
                            rx_tready <= 1'b0;
                            rsp_rdata <= '0;
                            rsp_resp  <= 2'b11;
                            rsp_valid <= ONE << cur.id;
                            state     <= S_DELIVER;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aximm_stream_client_arbiter.sv
// Scoreboard bench for aximm_stream_client_arbiter: expected grants, request
// packets and responses are queued as stimulus is issued and checked as the
// DUT produces them. A small server model answers request packets.
module tb_aximm_stream_client_arbiter;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_is_write = '0;
    logic [NR*64-1:0] req_addr = '0;
    logic [NR*32-1:0] req_wdata = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [15:0]     mismatch_count;

    aximm_stream_client_arbiter_if axis_if();

    aximm_stream_client_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .mismatch_count(mismatch_count),
        .axis(axis_if)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic [NR-1:0]  exp_grant_q[$];
    logic [255:0]   exp_tx_q[$];
    rsp_t           exp_rsp_q[$];
    logic [255:0]   srv_q[$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  tx_cnt = 0;
    int  rsp_cnt = 0;
    int  tx_hs_edge = 0;
    int  rsp_edge = 0;
    int  rr_left = 0;
    bit  srv_auto = 1'b1;
    logic [1:0] srv_resp = 2'b00;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_pkt(input logic [31:0] typ, input logic [63:0] a,
                                            input logic [31:0] d, input logic [1:0] r);
        logic [255:0] p;
        p = '0;
        p[31:0]    = typ;
        p[95:32]   = a;
        p[127:96]  = d;
        p[129:128] = r;
        return p;
    endfunction

    // Server memory model for read data.
    function automatic logic [31:0] rd_model(input logic [63:0] a);
        if (a == 64'h0000_0001_0000_0010) return 32'hDEAD_BEEF;
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int i, input bit w, input logic [63:0] a, input logic [31:0] d,
                            input logic [31:0] ed, input logic [1:0] er, input bit want_rsp);
        rsp_t r;
        exp_grant_q.push_back(NR'(1) << i);
        exp_tx_q.push_back(mk_pkt(w ? 32'd2 : 32'd1, a, w ? d : 32'd0, 2'b00));
        if (want_rsp) begin
            r.id = i; r.data = ed; r.resp = er;
            exp_rsp_q.push_back(r);
        end
    endtask

    task automatic set_req(input int i, input bit w, input logic [63:0] a, input logic [31:0] d);
        req_is_write[i]       = w;
        req_addr[i*64 +: 64]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic issue(input int i, input bit w, input logic [63:0] a, input logic [31:0] d,
                         input logic [31:0] ed, input logic [1:0] er, input bit want_rsp);
        @(posedge clk); #1;
        push_exp(i, w, a, d, ed, er, want_rsp);
        set_req(i, w, a, d);
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int k = 0; k < budget && rsp_cnt < target; k++) @(negedge clk);
        chk("wait_rsp", rsp_cnt, target);
    endtask

    task automatic wait_tx(input int target, input int budget);
        for (int k = 0; k < budget && tx_cnt < target; k++) @(negedge clk);
        chk("wait_tx", tx_cnt, target);
    endtask

    task automatic send_rx(input logic [255:0] d, input bit last);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        axis_if.AXIS_RX_TDATA  = d;
        axis_if.AXIS_RX_TLAST  = last;
        axis_if.AXIS_RX_TVALID = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (axis_if.AXIS_RX_TREADY) ok = 1'b1;
        end
        if (ok) @(posedge clk);
        #1;
        axis_if.AXIS_RX_TVALID = 1'b0;
        axis_if.AXIS_RX_TLAST  = 1'b0;
        axis_if.AXIS_RX_TDATA  = '0;
        chk("rx_accept", ok, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_resp"},  rsp_resp, 0);
        chk({tag, "_tx_tvalid"}, axis_if.AXIS_TX_TVALID, 0);
        chk({tag, "_tx_tlast"},  axis_if.AXIS_TX_TLAST, 0);
        chk({tag, "_tx_tdata"},  axis_if.AXIS_TX_TDATA, 0);
        chk({tag, "_rx_tready"}, axis_if.AXIS_RX_TREADY, 0);
        chk({tag, "_mismatch"},  mismatch_count, 0);
    endtask

    // Monitor: grants, request packets, TX hold and responses against the queues.
    initial begin
        bit           tv_pending;
        bit           prev_stall;
        logic [255:0] prev_data;
        logic [255:0] tx_exp;
        logic [NR-1:0] g_exp;
        rsp_t         r;
        tv_pending = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                tv_pending = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (tv_pending) begin
                    chk("tvalid_lat", axis_if.AXIS_TX_TVALID, 1);
                    tv_pending = 1'b0;
                end
                if (req_ready != '0) begin
                    if (exp_grant_q.size() == 0) chk("grant_unexp", req_ready, 0);
                    else begin
                        g_exp = exp_grant_q.pop_front();
                        chk("grant", req_ready, g_exp);
                    end
                    tv_pending = 1'b1;
                    if (rr_left > 0) begin
                        rr_left--;
                        if (rr_left == 0) req_valid = '0;
                    end else begin
                        req_valid = req_valid & ~req_ready;
                    end
                end
                if (prev_stall && axis_if.AXIS_TX_TVALID)
                    chk("tx_hold", axis_if.AXIS_TX_TDATA, prev_data);
                prev_stall = axis_if.AXIS_TX_TVALID && !axis_if.AXIS_TX_TREADY;
                prev_data  = axis_if.AXIS_TX_TDATA;
                if (axis_if.AXIS_TX_TVALID && axis_if.AXIS_TX_TREADY) begin
                    if (exp_tx_q.size() == 0) chk("tx_unexp", 1, 0);
                    else begin
                        tx_exp = exp_tx_q.pop_front();
                        chk("tx_pkt", axis_if.AXIS_TX_TDATA, tx_exp);
                    end
                    chk("tx_tlast", axis_if.AXIS_TX_TLAST, 1);
                    tx_cnt++;
                    tx_hs_edge = cyc + 1;
                    if (srv_auto) srv_q.push_back(axis_if.AXIS_TX_TDATA);
                end
                if (rsp_valid != '0) begin
                    if (exp_rsp_q.size() == 0) chk("rsp_unexp", rsp_valid, 0);
                    else begin
                        r = exp_rsp_q.pop_front();
                        chk("rsp_id",    rsp_valid, NR'(1) << r.id);
                        chk("rsp_rdata", rsp_rdata, r.data);
                        chk("rsp_resp",  rsp_resp, r.resp);
                    end
                    rsp_cnt++;
                    rsp_edge = cyc;
                end
            end
        end
    end

    // Auto-replying server.
    initial begin
        logic [255:0] p;
        forever begin
            @(posedge clk); #1;
            if (srv_auto && srv_q.size() > 0) begin
                p = srv_q.pop_front();
                if (p[31:0] == 32'd1)
                    send_rx(mk_pkt(32'd3, p[95:32], rd_model(p[95:32]), srv_resp), 1'b1);
                else
                    send_rx(mk_pkt(32'd4, p[95:32], p[127:96], srv_resp), 1'b1);
            end
        end
    end

    initial begin
        axis_if.AXIS_TX_TREADY = 1'b1;
        axis_if.AXIS_RX_TVALID = 1'b0;
        axis_if.AXIS_RX_TLAST  = 1'b0;
        axis_if.AXIS_RX_TDATA  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2 chk_reset("rst");
        @(negedge clk) resetn = 1'b1;

        // Round robin: all requesters valid continuously -> 0,1,2,3,0,1
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++)
            set_req(i, i[0], 64'h1000 + 64'(i) * 64'h100, 32'hA000_0000 + 32'(i));
        for (int k = 0; k < 6; k++) begin
            int i;
            i = k % NR;
            push_exp(i, i[0], 64'h1000 + 64'(i) * 64'h100, 32'hA000_0000 + 32'(i),
                     i[0] ? 32'hA000_0000 + 32'(i) : rd_model(64'h1000 + 64'(i) * 64'h100),
                     2'b00, 1'b1);
        end
        rr_left   = 6;
        req_valid = '1;
        wait_rsp(6, 400);

        // Single read
        issue(0, 1'b0, 64'h0000_0001_0000_0010, 32'h0, 32'hDEAD_BEEF, 2'b00, 1'b1);
        wait_rsp(7, 100);

        // TX backpressure on a write, BRESP=2
        axis_if.AXIS_TX_TREADY = 1'b0;
        srv_resp = 2'b10;
        issue(2, 1'b1, 64'h20, 32'h1234, 32'h1234, 2'b10, 1'b1);
        for (int k = 0; k < 20 && !axis_if.AXIS_TX_TVALID; k++) @(negedge clk);
        chk("bp_tvalid", axis_if.AXIS_TX_TVALID, 1);
        chk("bp_rx_tready", axis_if.AXIS_RX_TREADY, 0);
        repeat (10) @(posedge clk);
        #1 axis_if.AXIS_TX_TREADY = 1'b1;
        wait_rsp(8, 100);
        srv_resp = 2'b00;

        // Mismatched responses are dropped and counted
        srv_auto = 1'b0;
        issue(1, 1'b0, 64'h40, 32'h0, 32'h5555_AAAA, 2'b01, 1'b1);
        wait_tx(9, 50);
        send_rx(mk_pkt(32'd4, 64'h40, 32'h1111_1111, 2'b00), 1'b1);
        send_rx(mk_pkt(32'd3, 64'h44, 32'h2222_2222, 2'b00), 1'b1);
        send_rx(mk_pkt(32'd3, 64'h40, 32'h3333_3333, 2'b00), 1'b0);
        send_rx(mk_pkt(32'd3, 64'h40, 32'h5555_AAAA, 2'b01), 1'b1);
        wait_rsp(9, 50);
        chk("mm_count", mismatch_count, 3);
        repeat (3) @(negedge clk);
        chk("mm_rx_tready", axis_if.AXIS_RX_TREADY, 0);
        chk("rdata_hold", rsp_rdata, 32'h5555_AAAA);

        // Asynchronous reset while waiting for a response
        issue(3, 1'b0, 64'h80, 32'h0, 32'h0, 2'b00, 1'b0);
        wait_tx(10, 50);
        repeat (3) @(negedge clk);
        chk("wait_rx_tready", axis_if.AXIS_RX_TREADY, 1);
        #3 resetn = 1'b0;
        #1 chk_reset("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        srv_q.delete();
        srv_auto = 1'b1;
        issue(3, 1'b0, 64'h90, 32'h0, rd_model(64'h90), 2'b00, 1'b1);
        wait_rsp(10, 100);

`ifdef AXIS_CLIENT_TIMEOUT_EN
        // No reply: DECERR exactly 100 cycles after the request handshake
        begin
            int hs;
            srv_auto = 1'b0;
            issue(0, 1'b0, 64'h100, 32'h0, 32'h0, 2'b11, 1'b1);
            wait_tx(12, 50);
            hs = tx_hs_edge;
            wait_rsp(11, 300);
            chk("to_latency", rsp_edge - hs, 100);
            // The late reply lands in the next transaction's wait and is dropped
            issue(0, 1'b0, 64'h200, 32'h0, rd_model(64'h200), 2'b00, 1'b1);
            wait_tx(13, 50);
            send_rx(mk_pkt(32'd3, 64'h100, 32'h0, 2'b00), 1'b1);
            send_rx(mk_pkt(32'd3, 64'h200, rd_model(64'h200), 2'b00), 1'b1);
            wait_rsp(12, 50);
            chk("late_mm_count", mismatch_count, 1);
        end
`endif

        repeat (5) @(negedge clk);
        chk("queues_empty", exp_grant_q.size() + exp_tx_q.size() + exp_rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
